wb_trace_collector: RTL and testbench

- Consumer end of the `riscv_pipeline` writeback/debug interface.
- Watches `wb_e`/`wb_a`/`wb_d` and `pc_out`, and keeps a shadow register file of architectural writes.
- Decides when the run is over (PC limit, external request or timeout), waits for the pipeline to drain, then drives the pipeline `dump` strobe.
- Finally streams the 32 shadow registers out over a valid/ready port for self-checking benches and board-level readback.

---
 rtl/rvp_pkg.sv | 21 ++
 rtl/shadow_regfile.sv | 31 +++
 rtl/wb_trace_collector.sv | 128 ++++++++++++
 tb/tb_wb_trace_collector.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvp_pkg.sv
// Shared types for the riscv_pipeline writeback/debug interface and its trace collector.
package rvp_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned NREGS      = 32;
    localparam int unsigned REG_ADDR_W = $clog2(NREGS);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        DUMP,
        DONE
    } collector_state_t;

    typedef struct packed {
        logic                  en;
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } writeback_t;

endpackage

// File: rtl/shadow_regfile.sv
// Shadow copy of the architectural register file: one write port, one async read port,
// x0 hardwired to zero.
module shadow_regfile #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr,
    output logic [XLEN-1:0] rdata
);

    logic [XLEN-1:0] mem_q [NREGS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = (raddr == '0) ? '0 : mem_q[raddr];

endmodule

// File: rtl/wb_trace_collector.sv
// Captures pipeline writebacks into a shadow register file, ends the run, drains,
// pulses dump and streams the shadow registers out over valid/ready.
module wb_trace_collector #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned NREGS          = 32,
    parameter int unsigned PC_LIMIT       = 150,
    parameter int unsigned DRAIN_CYCLES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 200
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wb_e,
    input  logic [$clog2(NREGS)-1:0] wb_a,
    input  logic [XLEN-1:0]          wb_d,
    input  logic [XLEN-1:0]          pc_out,
    input  logic                     dump_req,
    output logic                     dump,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [$clog2(NREGS)-1:0] rd_idx,
    output logic [XLEN-1:0]          rd_data,
    output logic [31:0]              wb_count,
    output logic                     timed_out,
    output logic                     done
);

    import rvp_pkg::*;

    localparam int unsigned AW = $clog2(NREGS);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned DW = $clog2(DRAIN_CYCLES + 1);

    collector_state_t state;
    logic [TW-1:0]    run_cnt;
    logic [DW-1:0]    drain_cnt;
    logic [AW-1:0]    idx_q;
    logic             dump_q;
    logic             timed_out_q;
    logic [31:0]      wb_count_q;

    writeback_t wb_in;
    logic       capture;
    logic       pc_hit;
    logic       timeout_hit;
    logic       end_of_run;

    assign wb_in.en   = wb_e;
    assign wb_in.addr = wb_a;
    assign wb_in.data = wb_d;

    assign capture     = wb_in.en && (wb_in.addr != '0) && ((state == RUN) || (state == DRAIN));
    assign pc_hit      = pc_out >= XLEN'(PC_LIMIT);
    assign timeout_hit = run_cnt == TW'(TIMEOUT_CYCLES - 1);
    assign end_of_run  = pc_hit || dump_req || timeout_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            run_cnt     <= '0;
            drain_cnt   <= '0;
            idx_q       <= '0;
            dump_q      <= 1'b0;
            timed_out_q <= 1'b0;
            wb_count_q  <= '0;
        end else begin
            dump_q <= 1'b0;
            if (capture) begin
                wb_count_q <= wb_count_q + 32'd1;
            end
            unique case (state)
                RUN: begin
                    if (end_of_run) begin
                        state       <= DRAIN;
                        drain_cnt   <= '0;
                        // Timeout is only blamed when nothing else ended the run.
                        timed_out_q <= timeout_hit && !pc_hit && !dump_req;
                    end else begin
                        run_cnt <= run_cnt + TW'(1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DW'(DRAIN_CYCLES - 1)) begin
                        state  <= DUMP;
                        dump_q <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DW'(1);
                    end
                end
                DUMP: begin
                    if (rd_ready) begin
                        if (idx_q == AW'(NREGS - 1)) begin
                            state <= DONE;
                        end else begin
                            idx_q <= idx_q + AW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    shadow_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_shadow (
        .clk   (clk),
        .reset (reset),
        .we    (capture),
        .waddr (wb_in.addr),
        .wdata (wb_in.data),
        .raddr (idx_q),
        .rdata (rd_data)
    );

    assign dump      = dump_q;
    assign rd_valid  = (state == DUMP);
    assign done      = (state == DONE);
    assign rd_idx    = idx_q;
    assign wb_count  = wb_count_q;
    assign timed_out = timed_out_q;

    a_dump_single: assert property (@(posedge clk) disable iff (reset) dump |=> !dump);
    a_stall_hold: assert property (@(posedge clk) disable iff (reset)
        rd_valid && !rd_ready |=> $stable(rd_idx));
    a_done_sticky: assert property (@(posedge clk) disable iff (reset) done |=> done);

endmodule

// File: tb/tb_wb_trace_collector.sv
// Randomized and directed bench for wb_trace_collector against a cycle-level reference model.
module tb_wb_trace_collector;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_e;
    logic [4:0]  wb_a;
    logic [31:0] wb_d;
    logic [31:0] pc_out;
    logic        dump_req;
    logic        dump;
    logic        rd_valid;
    logic        rd_ready;
    logic [4:0]  rd_idx;
    logic [31:0] rd_data;
    logic [31:0] wb_count;
    logic        timed_out;
    logic        done;

    always #5 clk = ~clk;

    wb_trace_collector dut (
        .clk       (clk),
        .reset     (reset),
        .wb_e      (wb_e),
        .wb_a      (wb_a),
        .wb_d      (wb_d),
        .pc_out    (pc_out),
        .dump_req  (dump_req),
        .dump      (dump),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data),
        .wb_count  (wb_count),
        .timed_out (timed_out),
        .done      (done)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: run phase, how long it has lasted, and the register image.
    localparam int M_RUN = 0, M_DRAIN = 1, M_DUMP = 2, M_DONE = 3;
    int          m_phase, m_run, m_drain, m_idx, m_count;
    bit          m_timed, m_first_dump;
    logic [31:0] m_regs [32];

    int          cyc, dump_pulses, first_dump_cyc, hs_count;
    logic [31:0] seen [32];
    bit          stall_pending;
    logic [4:0]  stall_idx;
    logic [31:0] stall_data;

    function automatic void model_reset();
        m_phase = M_RUN; m_run = 0; m_drain = 0; m_idx = 0; m_count = 0;
        m_timed = 0; m_first_dump = 0;
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            seen[i]   = '0;
        end
        cyc = 0; dump_pulses = 0; first_dump_cyc = -1; hs_count = 0;
        stall_pending = 0;
    endfunction

    // Called at a falling edge; returns at the next falling edge.
    task automatic cycle(input logic e, input logic [4:0] a, input logic [31:0] d,
                         input logic [31:0] pc, input logic req, input logic rdy);
        bit acc;
        wb_e = e; wb_a = a; wb_d = d; pc_out = pc; dump_req = req; rd_ready = rdy;
        #1;
        check("dump", 32'(dump), 32'(m_phase == M_DUMP && m_first_dump));
        check("rd_valid", 32'(rd_valid), 32'(m_phase == M_DUMP));
        check("rd_idx", 32'(rd_idx), 32'(m_idx));
        if (m_phase == M_DUMP) check("rd_data", rd_data, m_regs[m_idx]);
        check("wb_count", wb_count, 32'(m_count));
        check("timed_out", 32'(timed_out), 32'(m_timed));
        check("done", 32'(done), 32'(m_phase == M_DONE));
        if (stall_pending) begin
            check("stall_idx", 32'(rd_idx), 32'(stall_idx));
            check("stall_data", rd_data, stall_data);
        end
        stall_pending = rd_valid && !rdy;
        stall_idx = rd_idx;
        stall_data = rd_data;
        if (dump) begin
            dump_pulses++;
            if (first_dump_cyc < 0) first_dump_cyc = cyc;
        end
        if (rd_valid && rdy) begin
            check("hs_order", 32'(rd_idx), 32'(hs_count));
            seen[rd_idx] = rd_data;
            hs_count++;
        end

        acc = (m_phase == M_RUN || m_phase == M_DRAIN) && e && (a != 0);
        case (m_phase)
            M_RUN: begin
                bit hit, to;
                hit = pc >= 150;
                to  = (m_run == 199);
                if (hit || req || to) begin
                    m_phase = M_DRAIN;
                    m_drain = 0;
                    m_timed = to && !hit && !req;
                end else begin
                    m_run++;
                end
            end
            M_DRAIN: begin
                m_drain++;
                if (m_drain == 4) begin
                    m_phase = M_DUMP;
                    m_first_dump = 1;
                end
            end
            M_DUMP: begin
                m_first_dump = 0;
                if (rdy) begin
                    if (m_idx == 31) m_phase = M_DONE;
                    else m_idx++;
                end
            end
            default: ;
        endcase
        if (acc) begin
            m_regs[a] = d;
            m_count++;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        #2 reset = 1'b1;
        #1;
        check("rst_dump", 32'(dump), 0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_rd_idx", 32'(rd_idx), 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_wb_count", wb_count, 0);
        check("rst_timed_out", 32'(timed_out), 0);
        check("rst_done", 32'(done), 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // rdy_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
    task automatic finish_run(input logic [31:0] pc, input logic req, input int rdy_mode);
        logic r;
        int   k;
        k = 0;
        while (m_phase != M_DONE && k < 600) begin
            case (rdy_mode)
                0: r = 1'b1;
                1: r = ((k % 4) == 0) || ((k % 4) == 3);
                default: r = 1'($urandom_range(0, 1));
            endcase
            cycle(1'b0, 5'd0, 32'd0, pc, req, r);
            k++;
        end
        cycle(1'b0, 5'd0, 32'd0, pc, req, 1'b1);
        check("run_done", 32'(done), 1);
    endtask

    initial begin
        int nz;
        reset = 1'b1; wb_e = 0; wb_a = 0; wb_d = 0; pc_out = 0; dump_req = 0; rd_ready = 0;
        model_reset();
        @(negedge clk);

        // Basic capture, x0 dropped, PC limit ends the run.
        apply_reset();
        cycle(1'b1, 5'd5, 32'h1234, 32'd0, 1'b0, 1'b1);
        cycle(1'b1, 5'd0, 32'hFFFF, 32'd4, 1'b0, 1'b1);
        cycle(1'b1, 5'd31, 32'hDEADBEEF, 32'd8, 1'b0, 1'b1);
        finish_run(32'd150, 1'b0, 0);
        check("s1_wb_count", wb_count, 2);
        check("s1_hs", 32'(hs_count), 32);
        check("s1_x0", seen[0], 0);
        check("s1_x5", seen[5], 32'h1234);
        check("s1_x31", seen[31], 32'hDEADBEEF);
        nz = 0;
        for (int i = 1; i < 31; i++) if (i != 5 && seen[i] != 0) nz++;
        check("s1_others_zero", 32'(nz), 0);
        check("s1_dump_pulses", 32'(dump_pulses), 1);
        check("s1_dump_cyc", 32'(first_dump_cyc), 8);

        // Timeout with PC parked below the limit.
        apply_reset();
        finish_run(32'd100, 1'b0, 2);
        check("s2_timed_out", 32'(timed_out), 1);
        check("s2_dump_cyc", 32'(first_dump_cyc), 204);
        check("s2_dump_pulses", 32'(dump_pulses), 1);

        // Last-DRAIN-cycle write captured, first-DUMP-cycle write ignored.
        apply_reset();
        cycle(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        cycle(1'b1, 5'd7, 32'h55, 32'd0, 1'b0, 1'b1);
        cycle(1'b1, 5'd8, 32'h66, 32'd0, 1'b0, 1'b1);
        finish_run(32'd0, 1'b0, 0);
        check("s3_x7", seen[7], 32'h55);
        check("s3_x8", seen[8], 0);
        check("s3_wb_count", wb_count, 1);
        check("s3_dump_cyc", 32'(first_dump_cyc), 5);

        // Backpressure pattern on the stream.
        apply_reset();
        for (int i = 0; i < 10; i++)
            cycle(1'b1, 5'($urandom_range(1, 31)), $urandom, 32'd0, 1'b0, 1'b1);
        finish_run(32'd200, 1'b0, 1);
        check("s4_hs", 32'(hs_count), 32);
        nz = 0;
        for (int i = 0; i < 32; i++) if (seen[i] !== m_regs[i]) nz++;
        check("s4_stream_image", 32'(nz), 0);

        // Simultaneous dump_req and PC limit, after sitting just below the limit.
        apply_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 5'd0, 32'd0, 32'd149, 1'b0, 1'b1);
        cycle(1'b0, 5'd0, 32'd0, 32'd150, 1'b1, 1'b1);
        finish_run(32'd150, 1'b1, 0);
        check("s5_timed_out", 32'(timed_out), 0);
        check("s5_dump_pulses", 32'(dump_pulses), 1);

        // Reset in the middle of the stream, then a clean new run.
        apply_reset();
        cycle(1'b1, 5'd3, 32'hAB, 32'd0, 1'b0, 1'b1);
        cycle(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1);
        for (int i = 0; i < 60 && !(m_phase == M_DUMP && m_idx == 10); i++)
            cycle(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        check("s6_reached_idx10", 32'(rd_idx), 10);
        apply_reset();
        cycle(1'b1, 5'd1, 32'h9, 32'd0, 1'b0, 1'b1);
        finish_run(32'd150, 1'b0, 0);
        check("s6_x1", seen[1], 32'h9);
        check("s6_x3_cleared", seen[3], 0);
        check("s6_wb_count", wb_count, 1);

        // Randomized runs.
        for (int r = 0; r < 6; r++) begin
            int k;
            apply_reset();
            k = 0;
            while (m_phase != M_DONE && k < 600) begin
                logic [31:0] pc;
                pc = ($urandom_range(0, 63) == 0) ? 32'(150 + $urandom_range(0, 9))
                                                  : 32'($urandom_range(0, 149));
                cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, pc,
                      ($urandom_range(0, 79) == 0), 1'($urandom_range(0, 1)));
                k++;
            end
            cycle(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1);
            check("rand_done", 32'(done), 1);
            check("rand_hs", 32'(hs_count), 32);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
